// File: rtl/mux_tree_pipe_pkg.sv
// rtl/mux_tree_pipe_pkg.sv - shared constants, width helpers and stage record for the mux tree
package mux_tree_pkg;

  localparam int DEF_SHIFT = 3;
  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 8;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Select width; never zero so select ports always exist.
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

  // Number of registered 2:1 levels.
  function automatic int lvl(input int n);
    return clog2(n);
  endfunction

  localparam int DEF_SEL_W = sel_w(DEF_N);

  // One pipeline stage record for the default geometry.
  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [DEF_SEL_W-1:0] sel_rem;
    logic [DEF_WIDTH-1:0] data;
  } stage_t;

endpackage

// File: rtl/mux_tree_pipe_mux2to1_reg.sv
// rtl/mux_tree_pipe_mux2to1_reg.sv - one registered 2:1 tree node with hold enable
module mux2to1_reg
  import mux_tree_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Pick a or b unless the pipeline is frozen.
  always_comb begin
    q_d = q_q;
    if (!hold) begin
      q_d = sel ? b : a;
    end
  end

  // Node data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined N-channel mux tree with valid/ready; optional MUX_TREE_PRECAL_EN shift stage
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter  int N     = DEF_N,
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int SHIFT = DEF_SHIFT,
  localparam int SEL_W = sel_w(N),
  localparam int LVL   = lvl(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int LEAVES = 1 << LVL;

  // Per-level control that travels alongside the data nodes.
  typedef struct packed {
    logic             valid;
    logic             err;
    logic [SEL_W-1:0] sel_rem;
  } ctl_t;

  ctl_t ctl_d [LVL];
  ctl_t ctl_q [LVL];
  logic lvl_sel [LVL];
  logic stall;

  // Heap-ordered tree: node 1 is the root, leaves sit at LEAVES..2*LEAVES-1.
  logic [WIDTH-1:0] tree [1:2*LEAVES-1];

  assign stall    = ctl_q[LVL-1].valid & ~out_ready;
  assign in_ready = ~stall;

  // Leaves: live channels (optionally pre-shifted) and zero padding.
  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < N) begin : g_live
      logic [WIDTH-1:0] ch;
      assign ch = in_data[i*WIDTH +: WIDTH];
`ifdef MUX_TREE_PRECAL_EN
      assign tree[LEAVES+i] = ch << SHIFT;
`else
      assign tree[LEAVES+i] = ch;
`endif
    end else begin : g_pad
      assign tree[LEAVES+i] = '0;
    end
  end

  // Registered 2:1 nodes, level k consumes select bit k.
  for (genvar k = 0; k < LVL; k++) begin : g_lvl
    localparam int BASE = 1 << (LVL - 1 - k);
    for (genvar j = 0; j < BASE; j++) begin : g_node
      mux2to1_reg #(
        .WIDTH(WIDTH)
      ) u_node (
        .clk  (clk),
        .rst_n(rst_n),
        .hold (stall),
        .sel  (lvl_sel[k]),
        .a    (tree[2*(BASE+j)]),
        .b    (tree[2*(BASE+j)+1]),
        .q    (tree[BASE+j])
      );
    end
  end

  // Select bit seen by each level: raw LSB at level 0, carried LSB afterwards.
  always_comb begin
    for (int k = 0; k < LVL; k++) begin
      lvl_sel[k] = 1'b0;
    end
    lvl_sel[0] = in_sel[0];
    for (int k = 1; k < LVL; k++) begin
      lvl_sel[k] = ctl_q[k-1].sel_rem[0];
    end
  end

  // Control advance: level 0 samples the input, later levels shift down; all hold on stall.
  always_comb begin
    for (int k = 0; k < LVL; k++) begin
      ctl_d[k] = ctl_q[k];
    end
    if (!stall) begin
      ctl_d[0].valid   = in_valid;
      ctl_d[0].err     = (int'(in_sel) >= N);
      ctl_d[0].sel_rem = in_sel >> 1;
      for (int k = 1; k < LVL; k++) begin
        ctl_d[k].valid   = ctl_q[k-1].valid;
        ctl_d[k].err     = ctl_q[k-1].err;
        ctl_d[k].sel_rem = ctl_q[k-1].sel_rem >> 1;
      end
    end
  end

  // Control registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LVL; k++) begin
        ctl_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LVL; k++) begin
        ctl_q[k] <= ctl_d[k];
      end
    end
  end

  assign out_data  = tree[1];
  assign out_err   = ctl_q[LVL-1].err;
  assign out_valid = ctl_q[LVL-1].valid;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - scoreboard bench for mux_tree_pipe (N=4 and N=5 instances)
`timescale 1ns/1ps
module tb_mux_tree_pipe;
  import mux_tree_pkg::*;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [4*W-1:0] d4_data  = '0;
  logic [1:0]     d4_sel   = '0;
  logic           d4_valid = 1'b0;
  logic           d4_ready;
  logic [W-1:0]   d4_odata;
  logic           d4_oerr;
  logic           d4_ovalid;
  logic           d4_oready = 1'b1;

  logic [5*W-1:0] d5_data  = '0;
  logic [2:0]     d5_sel   = '0;
  logic           d5_valid = 1'b0;
  logic           d5_ready;
  logic [W-1:0]   d5_odata;
  logic           d5_oerr;
  logic           d5_ovalid;
  logic           d5_oready = 1'b1;

  mux_tree_pipe #(.N(4), .WIDTH(W), .SHIFT(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4_data), .in_sel(d4_sel),
    .in_valid(d4_valid), .in_ready(d4_ready), .out_data(d4_odata),
    .out_err(d4_oerr), .out_valid(d4_ovalid), .out_ready(d4_oready)
  );

  mux_tree_pipe #(.N(5), .WIDTH(W), .SHIFT(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(d5_data), .in_sel(d5_sel),
    .in_valid(d5_valid), .in_ready(d5_ready), .out_data(d5_odata),
    .out_err(d5_oerr), .out_valid(d5_ovalid), .out_ready(d5_oready)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           acc;
    int           stalls;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];
  exp_t e4;
  exp_t e5;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   stall4   = 0;
  int   stall5   = 0;

  localparam logic [4*W-1:0] CH4 = {8'h44, 8'h33, 8'h22, 8'h11};
  localparam logic [5*W-1:0] CH5 = {8'h57, 8'h46, 8'h35, 8'h24, 8'h13};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hand-computed expectation for plain and pre-shifted builds.
  function automatic logic [W-1:0] ex(input logic [W-1:0] raw, input logic [W-1:0] pre);
`ifdef MUX_TREE_PRECAL_EN
    return pre;
`else
    return raw;
`endif
  endfunction

  task automatic send4(input logic [4*W-1:0] data, input logic [1:0] sel, input logic [W-1:0] exp);
    int waited;
    waited = 0;
    d4_data = data; d4_sel = sel; d4_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (d4_ready) begin
        q4.push_back('{exp, 1'b0, cyc, stall4});
        break;
      end
      waited++;
      if (waited > 20) begin
        check("send4_ready_timeout", {31'd0, d4_ready}, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    d4_valid = 1'b0;
  endtask

  task automatic send5(input logic [2:0] sel, input logic [W-1:0] exp, input logic err);
    int waited;
    waited = 0;
    d5_data = CH5; d5_sel = sel; d5_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (d5_ready) begin
        q5.push_back('{exp, err, cyc, stall5});
        break;
      end
      waited++;
      if (waited > 20) begin
        check("send5_ready_timeout", {31'd0, d5_ready}, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    d5_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor for the N=4 instance: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && d4_ovalid) begin
      if (!d4_oready) begin
        stall4++;
      end else if (q4.size() == 0) begin
        check("mon4_unexpected_output", {24'd0, d4_odata}, 32'hFFFF_FFFF);
      end else begin
        e4 = q4.pop_front();
        check("mon4_data", {24'd0, d4_odata}, {24'd0, e4.data});
        check("mon4_err", {31'd0, d4_oerr}, {31'd0, e4.err});
        check("mon4_latency", cyc, e4.acc + 2 + (stall4 - e4.stalls));
      end
    end
  end

  // Monitor for the N=5 instance.
  always @(negedge clk) begin
    if (rst_n && d5_ovalid) begin
      if (!d5_oready) begin
        stall5++;
      end else if (q5.size() == 0) begin
        check("mon5_unexpected_output", {24'd0, d5_odata}, 32'hFFFF_FFFF);
      end else begin
        e5 = q5.pop_front();
        check("mon5_data", {24'd0, d5_odata}, {24'd0, e5.data});
        check("mon5_err", {31'd0, d5_oerr}, {31'd0, e5.err});
        check("mon5_latency", cyc, e5.acc + 3 + (stall5 - e5.stalls));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'd0, d4_ovalid}, 32'd0);
    check("reset_out_data", {24'd0, d4_odata}, 32'd0);
    check("reset_out_err", {31'd0, d4_oerr}, 32'd0);
    check("reset_out_valid5", {31'd0, d5_ovalid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", {31'd0, d4_ready}, 32'd1);
    check("in_ready5_after_reset", {31'd0, d5_ready}, 32'd1);
    idle(1);

    // Single selection.
    send4(CH4, 2'd2, ex(8'h33, 8'h98));
    idle(4);

    // Back-to-back streaming.
    send4(CH4, 2'd0, ex(8'h11, 8'h88));
    send4(CH4, 2'd1, ex(8'h22, 8'h10));
    send4(CH4, 2'd2, ex(8'h33, 8'h98));
    send4(CH4, 2'd3, ex(8'h44, 8'h20));
    idle(4);

    // Backpressure for 3 cycles with the pipeline full.
    fork
      begin
        send4(CH4, 2'd3, ex(8'h44, 8'h20));
        send4(CH4, 2'd2, ex(8'h33, 8'h98));
        send4(CH4, 2'd1, ex(8'h22, 8'h10));
        send4(CH4, 2'd0, ex(8'h11, 8'h88));
      end
      begin
        int waited;
        waited = 0;
        do begin
          @(negedge clk);
          waited++;
        end while (!d4_ovalid && waited < 20);
        check("bp_first_output_seen", {31'd0, d4_ovalid}, 32'd1);
        @(posedge clk); #1 d4_oready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_in_ready_low", {31'd0, d4_ready}, 32'd0);
          check("bp_out_valid_held", {31'd0, d4_ovalid}, 32'd1);
          check("bp_out_data_held", {24'd0, d4_odata}, {24'd0, ex(8'h33, 8'h98)});
        end
        @(posedge clk); #1 d4_oready = 1'b1;
      end
    join
    idle(6);

    // Pre-calculation vector: channel 1 = 0x25.
    send4({8'h44, 8'h33, 8'h25, 8'h11}, 2'd1, ex(8'h25, 8'h28));
    idle(4);

    // N=5: out-of-range selects then valid channels.
    send5(3'd6, 8'h00, 1'b1);
    idle(4);
    send5(3'd4, ex(8'h57, 8'hB8), 1'b0);
    send5(3'd7, 8'h00, 1'b1);
    send5(3'd5, 8'h00, 1'b1);
    send5(3'd0, ex(8'h13, 8'h98), 1'b0);
    send5(3'd2, ex(8'h35, 8'hA8), 1'b0);
    idle(6);

    // Reset with two items in flight.
    send4(CH4, 2'd1, ex(8'h22, 8'h10));
    send4(CH4, 2'd2, ex(8'h33, 8'h98));
    rst_n = 1'b0;
    q4.delete();
    #1;
    check("midreset_out_valid", {31'd0, d4_ovalid}, 32'd0);
    check("midreset_out_data", {24'd0, d4_odata}, 32'd0);
    check("midreset_out_err", {31'd0, d4_oerr}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(8);
    send4(CH4, 2'd3, ex(8'h44, 8'h20));
    idle(6);

    check("q4_drained", q4.size(), 32'd0);
    check("q5_drained", q5.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, pipelined N-channel, WIDTH-bit multiplexer tree and the successor to the single-bit 2:1 mux tree. It registers every 2:1 tree level, carries the select bits down the pipeline and moves data through with a valid/ready handshake and a global stall. An optional compiled-in pre-calculation stage shifts each channel before selection. It sits between parallel producer channels and a single downstream consumer.

## Interface
- N, default 4: number of input channels; N ≥ 2, need not be a power of two.
- WIDTH, default 8: data width per channel.
- SHIFT, default 3: left-shift amount used by the pre-calculation stage.
- Derived: SEL_W = clog2(N); LVL = clog2(N), the number of pipeline levels.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_sel  input  SEL_W  channel index to forward.
- in_valid  input  1  in_data and in_sel are valid.
- in_ready  output  1  pipeline accepts the input this cycle.
- out_data  output  WIDTH  selected, optionally pre-calculated, data.
- out_err  output  1  the transfer carried an out-of-range select.
- out_valid  output  1  out_data and out_err are valid.
- out_ready  input  1  downstream accepts the output.

## Operation
- Leaf padding: the tree is built with 2^LVL leaves. Leaves at index N and above are tied to zero.
- Level k (k = 0..LVL-1):
  - Chooses between each pair of nodes using sel bit k, LSB first.
  - Registers the result, the remaining upper sel bits, a valid bit and an err bit.
- err is computed at the input as (in_sel ≥ N) and carried unchanged to the output.
  - An out-of-range select yields out_data = 0 and out_err = 1.
  - The transfer still completes as normal; it is not dropped.
- stall = out_valid & ~out_ready. While stall is high:
  - Every level register holds its contents.
  - in_ready = ~stall.
- An input is accepted when in_valid & in_ready.
  - Level 0 captures valid = in_valid whenever not stalled, so a bubble enters on in_valid = 0.
- Bubbles are not compressed. A stall freezes the whole pipeline, including empty stages.
- Output registers:
  - out_data, out_err and out_valid are driven directly from level LVL-1 registers.
  - No combinational path exists from in_* to out_*.
- Combinational ready path: in_ready depends combinationally on out_ready.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_err = 0, and every internal valid, data, sel and err register = 0.
- in_ready = 1 once rst_n is released, because out_valid = 0.
- Reset mid-operation: all in-flight transfers are discarded immediately. No partial output appears.
- Latency: exactly LVL cycles from the accepting edge to out_valid, provided there is no stall.
  - Example: N = 4 gives 2 cycles; N = 5 gives 3 cycles.
  - Each stalled cycle adds one cycle.
- Throughput: one transfer per cycle while out_ready = 1.
- Simultaneous events: an output handshake and an input acceptance in the same cycle are both legal. The pipeline advances by one.
- out_data and out_valid remain stable while out_valid = 1 and out_ready = 0.

## Configuration
- MUX_TREE_PRECAL_EN
  - Defined: each channel is transformed to (in << SHIFT), truncated to WIDTH, combinationally before level 0. Latency is unchanged.
  - Undefined: channels pass to the tree unmodified.
- Padded leaves and out-of-range selects still produce 0 in both builds.

## Structure
- Package mux_tree_pkg holds:
  - the clog2 function;
  - the SEL_W/LVL derivation;
  - the default SHIFT constant;
  - a packed stage_t typedef {valid, err, sel_rem, data}.
- Sub-module mux2to1_reg: one registered 2:1 node with a hold enable. It is instantiated 2^(LVL-1-k) times at level k.

## Test plan
- Selection (N = 4, WIDTH = 8, no precal, out_ready = 1): channels {0x11, 0x22, 0x33, 0x44}, in_sel = 2 accepted at cycle t -> out_data = 0x33, out_err = 0, out_valid = 1 at cycle t+2 and for one cycle only.
- Back-to-back streaming: in_sel = 0,1,2,3 on consecutive cycles -> out_data 0x11, 0x22, 0x33, 0x44 on consecutive cycles, no gaps.
- Backpressure: out_ready = 0 for 3 cycles while full -> in_ready = 0 and out_data held for those 3 cycles. On release, the remaining items emerge in order with none lost or duplicated.
- Out-of-range select (N = 5, LVL = 3): in_sel = 6 -> after 3 cycles out_data = 0, out_err = 1. A following in_sel = 4 -> channel 4 data with out_err = 0.
- Precal build (MUX_TREE_PRECAL_EN, SHIFT = 3, WIDTH = 8): channel 1 = 0x25, in_sel = 1 -> out_data = 0x28.
- Reset mid-flight: assert rst_n = 0 with 2 items in flight -> out_valid = 0 and out_data = 0 immediately. After release, no stale output appears.
